// File: rtl/dice_pkg.sv
// Shared constants, state encoding and face validity helper for the dice prize engine.
package dice_pkg;

    localparam int unsigned PRZ_NONE    = 0;
    localparam int unsigned PRZ_THREE   = 1;
    localparam int unsigned PRZ_FULL    = 2;
    localparam int unsigned PRZ_FOUR    = 3;
    localparam int unsigned PRZ_STRAIGHT = 4;
    localparam int unsigned PRZ_JACKPOT = 5;
    localparam int unsigned PRZ_W       = 6;

    typedef enum logic [1:0] {
        COLLECT,
        EVAL,
        DONE
    } state_t;

    function automatic logic face_is_valid(input int unsigned face, input int unsigned num_faces);
        return (face >= 1) && (face <= num_faces);
    endfunction

endpackage

// File: rtl/dice_hist_scan.sv
// Per-face histogram with an iterative scan producing max, second-max and distinct-face counts.
module dice_hist_scan #(
    parameter int unsigned NUM_FACES = 6,
    parameter int unsigned CNT_W     = 3,
    parameter int unsigned IDX_W     = 3,
    parameter int unsigned DIST_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    input  logic [IDX_W-1:0]  inc_face,
    input  logic              scan_en,
    input  logic [IDX_W-1:0]  scan_idx,
    output logic [CNT_W-1:0]  max_c,
    output logic [CNT_W-1:0]  second_c,
    output logic [DIST_W-1:0] distinct_c
);

    logic [CNT_W-1:0]  hist [NUM_FACES+1];
    logic [CNT_W-1:0]  max_q;
    logic [CNT_W-1:0]  second_q;
    logic [DIST_W-1:0] distinct_q;
    logic [CNT_W-1:0]  cur;

    // Fold the currently indexed face into the running statistics.
    always_comb begin
        cur        = hist[scan_idx];
        max_c      = max_q;
        second_c   = second_q;
        distinct_c = distinct_q + DIST_W'(cur != '0);
        if (cur > max_q) begin
            max_c    = cur;
            second_c = max_q;
        end else if (cur > second_q) begin
            second_c = cur;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hist       <= '{default: '0};
            max_q      <= '0;
            second_q   <= '0;
            distinct_q <= '0;
        end else begin
            if (inc) begin
                hist[inc_face] <= hist[inc_face] + CNT_W'(1);
            end
            if (scan_en) begin
                max_q      <= max_c;
                second_q   <= second_c;
                distinct_q <= distinct_c;
            end
        end
    end

endmodule

// File: rtl/dice_prize_engine.sv
// Collects NUM_DICE faces over a valid/ready stream, scans the histogram and
// presents a held one-hot prize classification with a completed-round counter.
module dice_prize_engine
    import dice_pkg::*;
#(
    parameter int unsigned NUM_DICE  = 6,
    parameter int unsigned FACE_W    = 3,
    parameter int unsigned NUM_FACES = 6,
    parameter int unsigned RND_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              die_valid,
    input  logic [FACE_W-1:0] die_face,
    output logic              die_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PRZ_W-1:0]  prize,
    output logic              err,
    output logic [RND_W-1:0]  round_cnt
);

    localparam int unsigned CNT_W  = $clog2(NUM_DICE + 1);
    localparam int unsigned IDX_W  = $clog2(NUM_FACES + 1);
    localparam int unsigned DMAX   = (NUM_FACES > NUM_DICE) ? NUM_FACES : NUM_DICE;
    localparam int unsigned DIST_W = $clog2(DMAX + 1);

    state_t            state;
    logic [CNT_W-1:0]  dcnt;
    logic              err_sticky;
    logic [IDX_W-1:0]  scan_idx;
    logic              face_ok;
    logic              accept;
    logic              inc;
    logic              scan_en;
    logic              hist_clr;
    logic [CNT_W-1:0]  max_c;
    logic [CNT_W-1:0]  second_c;
    logic [DIST_W-1:0] distinct_c;
    logic [PRZ_W-1:0]  prize_c;
    int unsigned       mx;
    int unsigned       sc;
    int unsigned       ds;

    assign die_ready = (state == COLLECT) && !clear;
    assign accept    = die_valid && die_ready;
    assign face_ok   = face_is_valid(32'(die_face), NUM_FACES);
    assign inc       = accept && face_ok;
    assign scan_en   = (state == EVAL) && !clear;
    assign hist_clr  = clear || ((state == DONE) && out_ready);

    dice_hist_scan #(
        .NUM_FACES (NUM_FACES),
        .CNT_W     (CNT_W),
        .IDX_W     (IDX_W),
        .DIST_W    (DIST_W)
    ) u_scan (
        .clk        (clk),
        .rst        (rst),
        .clr        (hist_clr),
        .inc        (inc),
        .inc_face   (IDX_W'(die_face)),
        .scan_en    (scan_en),
        .scan_idx   (scan_idx),
        .max_c      (max_c),
        .second_c   (second_c),
        .distinct_c (distinct_c)
    );

    // Priority classification on the statistics including the last scanned face.
    always_comb begin
        prize_c = '0;
        mx      = 32'(max_c);
        sc      = 32'(second_c);
        ds      = 32'(distinct_c);
        if (!err_sticky) begin
            if (mx == NUM_DICE)           prize_c[PRZ_JACKPOT]  = 1'b1;
            else if (ds == NUM_DICE)      prize_c[PRZ_STRAIGHT] = 1'b1;
            else if (mx >= 4)             prize_c[PRZ_FOUR]     = 1'b1;
            else if (mx == 3 && sc >= 2)  prize_c[PRZ_FULL]     = 1'b1;
            else if (mx == 3)             prize_c[PRZ_THREE]    = 1'b1;
            else                          prize_c[PRZ_NONE]     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= COLLECT;
            dcnt       <= '0;
            err_sticky <= 1'b0;
            scan_idx   <= '0;
            out_valid  <= 1'b0;
            prize      <= '0;
            err        <= 1'b0;
            round_cnt  <= '0;
        end else if (clear) begin
            state      <= COLLECT;
            dcnt       <= '0;
            err_sticky <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        dcnt       <= dcnt + CNT_W'(1);
                        err_sticky <= err_sticky | !face_ok;
                        if (dcnt == CNT_W'(NUM_DICE - 1)) begin
                            state    <= EVAL;
                            scan_idx <= IDX_W'(1);
                        end
                    end
                end
                EVAL: begin
                    scan_idx <= scan_idx + IDX_W'(1);
                    if (scan_idx == IDX_W'(NUM_FACES)) begin
                        prize     <= prize_c;
                        err       <= err_sticky;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        round_cnt  <= round_cnt + RND_W'(1);
                        dcnt       <= '0;
                        err_sticky <= 1'b0;
                        state      <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule
